// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between instruction fetch (port 0) and load/store (port 1).
module ram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    logic              r_last_gnt;
    logic              r_rd_owner_valid;
    logic              r_rd_owner;
    logic [7:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              w_tie1;
    logic              w_any;
    always_comb begin
        w_tie1      = (FIXED_PRIO != 0) ? (r_wait_cnt != 8'(MAX_WAIT)) : !r_last_gnt;
        p1_gnt      = p1_req && (!p0_req || w_tie1);
        p0_gnt      = p0_req && !p1_gnt;
        w_any       = p0_gnt || p1_gnt;
        ram_wr_en   = p1_gnt ? p1_we : (p0_gnt && p0_we);
        ram_address = p1_gnt ? p1_addr : (p0_gnt ? p0_addr : r_addr_hold);
        ram_data_in = p1_gnt ? p1_wdata : p0_wdata;
    end
    // Idle cycles keep the last address on the RAM: an idle read is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt       <= 1'b1;
            r_rd_owner_valid <= 1'b0;
            r_rd_owner       <= 1'b0;
            r_wait_cnt       <= 8'd0;
            r_addr_hold      <= '0;
        end else begin
            if (w_any) begin
                r_last_gnt  <= p1_gnt;
                r_rd_owner  <= p1_gnt;
                r_addr_hold <= ram_address;
            end
            r_rd_owner_valid <= w_any && !ram_wr_en;
            r_wait_cnt <= (FIXED_PRIO != 0 && p0_req && !p0_gnt)
                        ? ((r_wait_cnt == 8'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + 8'd1)
                        : 8'd0;
        end
    end
    assign p0_rvalid = r_rd_owner_valid && !r_rd_owner;
    assign p1_rvalid = r_rd_owner_valid && r_rd_owner;
    assign p0_rdata  = ram_data_out;
    assign p1_rdata  = ram_data_out;
endmodule
